// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one 64-bit data memory between the CPU memory stage and a
// burst DMA port; CPU has priority, bounded by a starvation counter. Rev 1.0
`default_nettype none

module dmem_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  // CPU memory stage
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  output logic [63:0] cpu_rdata,
  output logic        cpu_stall,
  // DMA / debug port
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [63:0] dma_addr,
  input  logic [3:0]  dma_len,
  output logic        dma_gnt,
  input  logic [63:0] dma_wdata,
  output logic        dma_wready,
  output logic [63:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        dma_done,
  // data memory
  output logic [63:0] mem_address,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [63:0] mem_write_data,
  output logic [3:0]  mem_xfer_size,
  input  logic [63:0] mem_read_data
);

  localparam int             SW         = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0]  STARVE_MAX = SW'(MAX_WAIT);
  localparam logic [3:0]     LEN_MAX    = 4'(BURST_MAX);

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        state_q,  state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [63:0]   addr_q,   addr_d;
  logic [3:0]    remain_q, remain_d;
  logic          we_q,     we_d;
  logic [63:0]   rdata_q,  rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          done_q,   done_d;

  logic       grant;
  logic [3:0] len_clamped;

  always_comb begin
    if (dma_len == 4'd0)         len_clamped = 4'd1;
    else if (dma_len > LEN_MAX)  len_clamped = LEN_MAX;
    else                         len_clamped = dma_len;
  end

  assign grant = dma_req & (~(cpu_read | cpu_write) | (starve_q == STARVE_MAX));

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;

    mem_address      = cpu_addr;
    mem_write_enable = cpu_write;
    mem_read_enable  = cpu_read & ~cpu_write;
    mem_write_data   = cpu_wdata;
    cpu_rdata        = mem_read_data;
    cpu_stall        = 1'b0;
    dma_gnt          = 1'b0;
    dma_wready       = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant) begin
          dma_gnt  = 1'b1;
          addr_d   = dma_addr;
          remain_d = len_clamped;
          we_d     = dma_we;
          starve_d = '0;
          state_d  = BURST;
        end else if (dma_req) begin
          if (starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
        end else begin
          starve_d = '0;
        end
      end
      BURST: begin
        // The burst owns the memory outright; CPU stores are dropped, not merged.
        mem_address      = addr_q;
        mem_write_enable = we_q;
        mem_read_enable  = ~we_q;
        mem_write_data   = dma_wdata;
        cpu_rdata        = '0;
        cpu_stall        = cpu_read | cpu_write;
        dma_wready       = we_q;
        if (!we_q) begin
          rdata_d  = mem_read_data;
          rvalid_d = 1'b1;
        end
        addr_d   = addr_q + 64'd8;
        remain_d = remain_q - 4'd1;
        if (remain_q <= 4'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      remain_q <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end

  assign dma_rdata     = rdata_q;
  assign dma_rvalid    = rvalid_q;
  assign dma_done      = done_q;
  assign mem_xfer_size = 4'b1000;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors and burst sequences for dmem_arbiter against a
// small word-addressed memory model. Rev 1.0
`default_nettype none

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_read, cpu_write;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we, dma_gnt, dma_wready, dma_rvalid, dma_done;
  logic [63:0] dma_addr, dma_wdata, dma_rdata;
  logic [3:0]  dma_len;
  logic [63:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable;
  logic [3:0]  mem_xfer_size;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(4), .BURST_MAX(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_gnt(dma_gnt), .dma_wdata(dma_wdata), .dma_wready(dma_wready),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_done(dma_done),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_write_data(mem_write_data),
    .mem_xfer_size(mem_xfer_size), .mem_read_data(mem_read_data)
  );

  // 128-word memory; test addresses are chosen so that bits [9:3] never alias.
  logic [63:0] mem_arr [0:127];
  initial for (int i = 0; i < 128; i++) mem_arr[i] = 64'd0;
  always @(posedge clk) if (mem_write_enable) mem_arr[mem_address[9:3]] <= mem_write_data;
  assign mem_read_data = mem_arr[mem_address[9:3]];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_we;
    logic        exp_re;
    logic        chk_rdata;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_rd_chk(input logic [63:0] a, input logic [63:0] exp);
    cpu_read = 1'b1;
    cpu_addr = a;
    @(negedge clk);
    chk("cpu_rd", cpu_rdata, exp);
    chk("cpu_rd_stall", 64'(cpu_stall), 64'd0);
    next_cycle();
    cpu_read = 1'b0;
  endtask

  // Write burst with the CPU idle: grant is immediate, beats follow, done after.
  task automatic run_wburst(input logic [63:0] a, input logic [3:0] l, input int nb,
                            input logic [63:0] base);
    dma_req  = 1'b1;
    dma_addr = a;
    dma_len  = l;
    dma_we   = 1'b1;
    @(negedge clk);
    chk("wb_gnt", 64'(dma_gnt), 64'd1);
    next_cycle();
    dma_req = 1'b0;
    for (int c = 1; c <= nb + 1; c++) begin
      dma_wdata = base + 64'(c);
      @(negedge clk);
      chk("wb_wready", 64'(dma_wready), 64'(c <= nb));
      chk("wb_done", 64'(dma_done), 64'(c == nb + 1));
      chk("wb_gnt_low", 64'(dma_gnt), 64'd0);
      if (c <= nb) chk("wb_addr", mem_address, a + 64'(8 * (c - 1)));
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{1'b0, 1'b1, 64'h40, 64'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 64'h0};
    vt[1] = '{1'b1, 1'b0, 64'h40, 64'h0,         1'b0, 1'b1, 1'b1, 64'hDEAD_BEEF};
    vt[2] = '{1'b1, 1'b1, 64'h48, 64'h1234,      1'b1, 1'b0, 1'b0, 64'h0};
    vt[3] = '{1'b1, 1'b0, 64'h48, 64'h0,         1'b0, 1'b1, 1'b1, 64'h1234};
    vt[4] = '{1'b0, 1'b0, 64'h40, 64'h55,        1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF};

    reset_n = 1'b1;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
    #2 reset_n = 1'b0;
    #5;
    chk("rst_gnt", 64'(dma_gnt), 64'd0);
    chk("rst_rvalid", 64'(dma_rvalid), 64'd0);
    chk("rst_done", 64'(dma_done), 64'd0);
    chk("rst_rdata", dma_rdata, 64'd0);
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("xfer_size", 64'(mem_xfer_size), 64'h8);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    next_cycle();

    // CPU-only vectors
    for (int i = 0; i < 5; i++) begin
      cpu_read = vt[i].rd; cpu_write = vt[i].wr;
      cpu_addr = vt[i].addr; cpu_wdata = vt[i].wdata;
      @(negedge clk);
      chk("v_we", 64'(mem_write_enable), 64'(vt[i].exp_we));
      chk("v_re", 64'(mem_read_enable), 64'(vt[i].exp_re));
      chk("v_addr", mem_address, vt[i].addr);
      chk("v_wdata", mem_write_data, vt[i].wdata);
      chk("v_stall", 64'(cpu_stall), 64'd0);
      if (vt[i].chk_rdata) chk("v_rdata", cpu_rdata, vt[i].exp_rdata);
      next_cycle();
    end
    cpu_read = 1'b0; cpu_write = 1'b0;

    // 4-beat write burst, then read it back through the CPU port
    run_wburst(64'h100, 4'd4, 4, 64'd0);
    for (int k = 0; k < 4; k++) cpu_rd_chk(64'h100 + 64'(8 * k), 64'(k + 1));

    // Read burst against continuous CPU loads: grant only after starving MAX_WAIT cycles
    cpu_read = 1'b1; cpu_addr = 64'h40;
    dma_req = 1'b1; dma_addr = 64'h100; dma_len = 4'd4; dma_we = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rb_wait_gnt", 64'(dma_gnt), 64'd0);
      chk("rb_wait_rdata", cpu_rdata, 64'hDEAD_BEEF);
      next_cycle();
    end
    @(negedge clk);
    chk("rb_gnt", 64'(dma_gnt), 64'd1);
    chk("rb_gnt_stall", 64'(cpu_stall), 64'd0);
    next_cycle();
    dma_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cpu_write = (k == 3);
      cpu_wdata = 64'hBAD;
      @(negedge clk);
      chk("rb_stall", 64'(cpu_stall), 64'd1);
      chk("rb_we_blocked", 64'(mem_write_enable), 64'd0);
      chk("rb_re", 64'(mem_read_enable), 64'd1);
      chk("rb_cpu_rdata", cpu_rdata, 64'd0);
      chk("rb_addr", mem_address, 64'h100 + 64'(8 * (k - 1)));
      chk("rb_rvalid", 64'(dma_rvalid), 64'(k >= 2));
      chk("rb_done", 64'(dma_done), 64'd0);
      if (k >= 2) chk("rb_rdata", dma_rdata, 64'(k - 1));
      next_cycle();
    end
    cpu_write = 1'b0;
    @(negedge clk);
    chk("rb_last_rvalid", 64'(dma_rvalid), 64'd1);
    chk("rb_last_rdata", dma_rdata, 64'd4);
    chk("rb_done_pulse", 64'(dma_done), 64'd1);
    chk("rb_end_stall", 64'(cpu_stall), 64'd0);
    chk("rb_end_cpu_rdata", cpu_rdata, 64'hDEAD_BEEF);
    next_cycle();
    @(negedge clk);
    chk("rb_rvalid_off", 64'(dma_rvalid), 64'd0);
    chk("rb_done_off", 64'(dma_done), 64'd0);
    next_cycle();
    cpu_read = 1'b0;

    // Length boundaries and address wrap
    run_wburst(64'h200, 4'd0, 1, 64'hA9);
    cpu_rd_chk(64'h200, 64'hAA);
    run_wburst(64'h300, 4'd15, 8, 64'h10);
    cpu_rd_chk(64'h338, 64'h18);
    cpu_rd_chk(64'h340, 64'h0);
    run_wburst(64'hFFFF_FFFF_FFFF_FFF8, 4'd2, 2, 64'h70);
    cpu_rd_chk(64'hFFFF_FFFF_FFFF_FFF8, 64'h71);
    cpu_rd_chk(64'h0, 64'h72);

    // Reset just after beat 2 of a 6-beat write burst
    cpu_addr = 64'h48;
    dma_req = 1'b1; dma_addr = 64'h180; dma_len = 4'd6; dma_we = 1'b1;
    @(negedge clk);
    chk("rs_gnt", 64'(dma_gnt), 64'd1);
    next_cycle();
    dma_req = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      dma_wdata = 64'h50 + 64'(k);
      @(negedge clk);
      chk("rs_wready", 64'(dma_wready), 64'd1);
      next_cycle();
    end
    reset_n = 1'b0;
    dma_wdata = 64'h53;
    #1;
    chk("rs_wready_off", 64'(dma_wready), 64'd0);
    chk("rs_we_off", 64'(mem_write_enable), 64'd0);
    chk("rs_addr_cpu", mem_address, 64'h48);
    chk("rs_rdata", dma_rdata, 64'd0);
    chk("rs_done", 64'(dma_done), 64'd0);
    chk("rs_gnt_off", 64'(dma_gnt), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    cpu_rd_chk(64'h180, 64'h51);
    cpu_rd_chk(64'h188, 64'h52);
    cpu_rd_chk(64'h190, 64'h0);
    run_wburst(64'h1C0, 4'd2, 2, 64'h60);
    cpu_rd_chk(64'h1C8, 64'h62);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
